// File: rtl/draw_number_ctrl_pkg.sv
// Shared constants and types for the number-drawing controller.
// Holds default pixel geometry, the ASCII base for digit glyphs,
// the character renderer mode encodings and the controller FSM state type.
package draw_number_ctrl_pkg;

    localparam int PIXEL_X_WIDTH_DEF = 10;
    localparam int PIXEL_Y_WIDTH_DEF = 9;
    localparam int PIXEL_X_MAX_DEF   = 639;
    localparam int PIXEL_Y_MAX_DEF   = 479;

    localparam logic [7:0] CHAR_ZERO = 8'h30;

    localparam logic [1:0] MODE_POS_CODE   = 2'b00;
    localparam logic [1:0] MODE_COLOR_SIZE = 2'b01;
    localparam logic [1:0] MODE_FULL_LOAD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL,
        ST_ISSUE,
        ST_WAIT,
        ST_FIN
    } state_t;

endpackage

// File: rtl/draw_number_ctrl_if.sv
// Character renderer link: position/code/size/colour load bus with strobe,
// and the renderer's completion pulse back to the controller.
// master = controller (drives the load bus), slave = character renderer.
interface draw_number_ctrl_if #(
    parameter int PXW = 10,
    parameter int PYW = 9,
    parameter int CIW = 8,
    parameter int CCW = 8
) ();
    logic [PXW-1:0] ch_x;
    logic [PYW-1:0] ch_y;
    logic [CCW-1:0] ch_code;
    logic [3:0]     ch_size;
    logic [1:0]     ch_mode;
    logic [CIW-1:0] ch_idata;
    logic           ch_idata_vld;
    logic           ch_done;

    modport master (
        output ch_x, ch_y, ch_code, ch_size, ch_mode, ch_idata, ch_idata_vld,
        input  ch_done
    );

    modport slave (
        input  ch_x, ch_y, ch_code, ch_size, ch_mode, ch_idata, ch_idata_vld,
        output ch_done
    );
endinterface

// File: rtl/draw_number_ctrl.sv
// Draws a BCD number as a row of character glyphs by issuing one load per
// digit to a character renderer and waiting for its completion pulse.
// Ports: clk/rst (async active-high); start + captured request fields
// (value, ndig, lz, x, y, size, color); status busy/done/clipped;
// ch = renderer link (master side).
//
// state    | meaning
// IDLE     | waiting for start
// EVAL     | clip / skip / draw decision for the current digit
// ISSUE    | load strobe to the renderer
// WAIT     | waiting for renderer completion
// FIN      | done pulse
module draw_number_ctrl
    import draw_number_ctrl_pkg::*;
#(
    parameter int PIXEL_X_WIDTH   = PIXEL_X_WIDTH_DEF,
    parameter int PIXEL_Y_WIDTH   = PIXEL_Y_WIDTH_DEF,
    parameter int PIXEL_X_MAX     = PIXEL_X_MAX_DEF,
    parameter int PIXEL_Y_MAX     = PIXEL_Y_MAX_DEF,
    parameter int COLOR_ID_WIDTH  = 8,
    parameter int CHAR_CODE_WIDTH = 8,
    parameter int NUM_DIGITS_MAX  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [4*NUM_DIGITS_MAX-1:0] value,
    input  logic [2:0]                  ndig,
    input  logic                        lz,
    input  logic [PIXEL_X_WIDTH-1:0]    x,
    input  logic [PIXEL_Y_WIDTH-1:0]    y,
    input  logic [3:0]                  size,
    input  logic [COLOR_ID_WIDTH-1:0]   color,
    output logic                        busy,
    output logic                        done,
    output logic                        clipped,
    draw_number_ctrl_if.master          ch
);

    localparam int VW  = 4*NUM_DIGITS_MAX;
    localparam int XW1 = PIXEL_X_WIDTH + 1;
    localparam int XEW = PIXEL_X_WIDTH + 2;
    localparam int YEW = PIXEL_Y_WIDTH + 2;

    state_t state, state_n;

    logic [VW-1:0]              val_q;
    logic [2:0]                 nd_q;
    logic [2:0]                 idx;
    logic                       lz_q;
    logic                       seen_nz;
    logic [XW1-1:0]             xcur;
    logic [PIXEL_Y_WIDTH-1:0]   y_q;
    logic [3:0]                 size_q;
    logic [COLOR_ID_WIDTH-1:0]  color_q;
    logic                       clipped_q;

    logic [PIXEL_X_WIDTH-1:0]   ch_x_q;
    logic [PIXEL_Y_WIDTH-1:0]   ch_y_q;
    logic [CHAR_CODE_WIDTH-1:0] ch_code_q;
    logic [3:0]                 ch_size_q;
    logic [COLOR_ID_WIDTH-1:0]  ch_idata_q;
    logic [1:0]                 ch_mode_q;

    logic [2:0]     nd_clamp;
    logic [VW-1:0]  val_aligned;
    logic [3:0]     nib;
    logic           last;
    logic [4:0]     s1;
    logic [6:0]     pitch;
    logic [7:0]     height;
    logic [XEW-1:0] x_end;
    logic [YEW-1:0] y_end;
    logic           clip;
    logic           accept, eval_clip, eval_skip, eval_draw, advance;

    // Request fields are left-aligned so the digit being evaluated is always
    // the top nibble; advancing is then a plain shift.
    always_comb begin
        nd_clamp = ndig;
        if (ndig == 3'd0)
            nd_clamp = 3'd1;
        else if (int'(ndig) > NUM_DIGITS_MAX)
            nd_clamp = 3'(NUM_DIGITS_MAX);
        val_aligned = value << (4 * (NUM_DIGITS_MAX - int'(nd_clamp)));
    end

    assign nib  = val_q[VW-1 -: 4];
    assign last = (idx == nd_q - 3'd1);

    // Pitch 6*(size+1) and height 10*(size+1) as shift-and-add.
    assign s1     = {1'b0, size_q} + 5'd1;
    assign pitch  = {s1, 2'b00} + {1'b0, s1, 1'b0};
    assign height = {s1, 3'b000} + {2'b00, s1, 1'b0};

    // Compare the exclusive end against MAX+1 to avoid the -1 underflow.
    assign x_end = {1'b0, xcur} + XEW'(pitch);
    assign y_end = {2'b00, y_q} + YEW'(height);
    assign clip  = (x_end > XEW'(PIXEL_X_MAX + 1)) || (y_end > YEW'(PIXEL_Y_MAX + 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        eval_clip = 1'b0;
        eval_skip = 1'b0;
        eval_draw = 1'b0;
        advance   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (clip) begin
                    eval_clip = 1'b1;
                    state_n   = ST_FIN;
                end else if (lz_q && nib == 4'd0 && !seen_nz && !last) begin
                    eval_skip = 1'b1;
                end else begin
                    eval_draw = 1'b1;
                    state_n   = ST_ISSUE;
                end
            end
            ST_ISSUE: state_n = ST_WAIT;
            ST_WAIT: begin
                if (ch.ch_done) begin
                    if (last) begin
                        state_n = ST_FIN;
                    end else begin
                        advance = 1'b1;
                        state_n = ST_EVAL;
                    end
                end
            end
            ST_FIN:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q      <= '0;
            nd_q       <= '0;
            idx        <= '0;
            lz_q       <= 1'b0;
            seen_nz    <= 1'b0;
            xcur       <= '0;
            y_q        <= '0;
            size_q     <= '0;
            color_q    <= '0;
            clipped_q  <= 1'b0;
            ch_x_q     <= '0;
            ch_y_q     <= '0;
            ch_code_q  <= '0;
            ch_size_q  <= '0;
            ch_idata_q <= '0;
            ch_mode_q  <= '0;
        end else begin
            ch_mode_q <= MODE_FULL_LOAD;
            if (accept) begin
                val_q     <= val_aligned;
                nd_q      <= nd_clamp;
                idx       <= '0;
                lz_q      <= lz;
                seen_nz   <= 1'b0;
                xcur      <= {1'b0, x};
                y_q       <= y;
                size_q    <= size;
                color_q   <= color;
                clipped_q <= 1'b0;
            end
            if (eval_skip || advance) begin
                val_q <= val_q << 4;
                idx   <= idx + 3'd1;
                xcur  <= xcur + XW1'(pitch);
            end
            if (eval_clip)
                clipped_q <= 1'b1;
            if (eval_draw) begin
                ch_x_q     <= xcur[PIXEL_X_WIDTH-1:0];
                ch_y_q     <= y_q;
                ch_code_q  <= CHAR_CODE_WIDTH'(CHAR_ZERO) + CHAR_CODE_WIDTH'(nib);
                ch_size_q  <= size_q;
                ch_idata_q <= color_q;
                if (nib != 4'd0)
                    seen_nz <= 1'b1;
            end
        end
    end

    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_FIN);
    assign clipped = clipped_q;

    assign ch.ch_x         = ch_x_q;
    assign ch.ch_y         = ch_y_q;
    assign ch.ch_code      = ch_code_q;
    assign ch.ch_size      = ch_size_q;
    assign ch.ch_mode      = ch_mode_q;
    assign ch.ch_idata     = ch_idata_q;
    assign ch.ch_idata_vld = (state == ST_ISSUE);

endmodule
